// File: rtl/step_dir_gen.sv
// Step/dir pulse generator: turns signed relative move commands into timed step
// pulses with guaranteed dir setup, tracking the commanded position.
module step_dir_gen #(
    parameter int CNT_W = 32,
    parameter int TIM_W = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic [TIM_W-1:0] step_period,
    input  logic [TIM_W-1:0] step_high,
    input  logic [TIM_W-1:0] dir_setup,
    input  logic             step_active_high,
    input  logic             invert_dir,
    input  logic             abort,
    input  logic             pos_set_valid,
    input  logic [CNT_W-1:0] pos_set_value,
    output logic             step,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] position,
    output logic [1:0]       state_dbg
);

    // Handshake: a command transfers on a rising clk edge where cmd_valid and
    // cmd_ready are both high; cmd_ready is high only in IDLE and does not depend on cmd_valid.

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SETUP    = 2'd1,
        S_PULSE_HI = 2'd2,
        S_PULSE_LO = 2'd3
    } state_t;

    localparam logic [TIM_W-1:0] TIM_ONE = TIM_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t            state_q, state_d;
    logic [TIM_W-1:0]  timer_q, timer_d;
    logic [TIM_W-1:0]  hi_rel_q, hi_rel_d;
    logic [TIM_W-1:0]  lo_rel_q, lo_rel_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic [CNT_W-1:0]  position_q, position_d;
    logic              step_q, step_d;
    logic              dir_q, dir_d;
    logic              done_q, done_d;
    logic              abort_q, abort_d;
    logic              act_q, act_d;
    logic              neg_q, neg_d;

    logic accept;
    logic cmd_zero;
    logic timer_zero;
    logic start_move;
    logic fire;
    logic to_lo;
    logic finish;

    assign accept     = cmd_valid && (state_q == S_IDLE);
    assign cmd_zero   = (cmd_steps == '0);
    assign timer_zero = (timer_q == '0);

    // State register and datapath flops
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            hi_rel_q    <= '0;
            lo_rel_q    <= '0;
            remaining_q <= '0;
            position_q  <= '0;
            step_q      <= ~step_active_high;
            dir_q       <= 1'b0;
            done_q      <= 1'b0;
            abort_q     <= 1'b0;
            act_q       <= step_active_high;
            neg_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            hi_rel_q    <= hi_rel_d;
            lo_rel_q    <= lo_rel_d;
            remaining_q <= remaining_d;
            position_q  <= position_d;
            step_q      <= step_d;
            dir_q       <= dir_d;
            done_q      <= done_d;
            abort_q     <= abort_d;
            act_q       <= act_d;
            neg_q       <= neg_d;
        end
    end

    // Next-state logic; also produces the one-cycle event strobes the datapath uses
    always_comb begin
        state_d    = state_q;
        start_move = 1'b0;
        fire       = 1'b0;
        to_lo      = 1'b0;
        finish     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept && !cmd_zero) begin
                    state_d    = S_SETUP;
                    start_move = 1'b1;
                end
            end
            S_SETUP: begin
                if (abort || abort_q) begin
                    state_d = S_IDLE;
                    finish  = 1'b1;
                end else if (timer_zero) begin
                    state_d = S_PULSE_HI;
                    fire    = 1'b1;
                end
            end
            S_PULSE_HI: begin
                if (timer_zero) begin
                    state_d = S_PULSE_LO;
                    to_lo   = 1'b1;
                end
            end
            S_PULSE_LO: begin
                if (timer_zero) begin
                    if ((remaining_q == '0) || abort_q || abort) begin
                        state_d = S_IDLE;
                        finish  = 1'b1;
                    end else begin
                        state_d = S_PULSE_HI;
                        fire    = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: timers, counters, pin levels
    always_comb begin
        timer_d     = timer_q;
        hi_rel_d    = hi_rel_q;
        lo_rel_d    = lo_rel_q;
        remaining_d = remaining_q;
        position_d  = position_q;
        step_d      = step_q;
        dir_d       = dir_q;
        done_d      = 1'b0;
        abort_d     = abort_q;
        act_d       = act_q;
        neg_d       = neg_q;

        if (state_q == S_IDLE) begin
            step_d  = ~step_active_high;
            abort_d = 1'b0;
            if (accept) begin
                if (cmd_zero) begin
                    done_d = 1'b1;
                end
            end else if (pos_set_valid) begin
                position_d = pos_set_value;
            end
        end else begin
            if (abort) begin
                abort_d = 1'b1;
            end
            if (!timer_zero) begin
                timer_d = timer_q - TIM_ONE;
            end
        end

        // Timer reloads hold "cycles minus one" so a zero timer marks the last cycle of a phase
        if (start_move) begin
            remaining_d = cmd_steps[CNT_W-1] ? ('0 - cmd_steps) : cmd_steps;
            hi_rel_d    = (step_high == '0) ? '0 : (step_high - TIM_ONE);
            lo_rel_d    = (step_period > step_high) ? (step_period - step_high - TIM_ONE) : '0;
            timer_d     = dir_setup;
            dir_d       = (~cmd_steps[CNT_W-1]) ^ invert_dir;
            neg_d       = cmd_steps[CNT_W-1];
            act_d       = step_active_high;
            abort_d     = 1'b0;
        end

        if (fire) begin
            step_d      = act_q;
            position_d  = neg_q ? (position_q - CNT_ONE) : (position_q + CNT_ONE);
            remaining_d = remaining_q - CNT_ONE;
            timer_d     = hi_rel_q;
        end

        if (to_lo) begin
            step_d  = ~act_q;
            timer_d = lo_rel_q;
        end

        if (finish) begin
            step_d  = ~act_q;
            done_d  = 1'b1;
            abort_d = 1'b0;
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign step      = step_q;
    assign dir       = dir_q;
    assign done      = done_q;
    assign position  = position_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_step_dir_gen.sv
// Bench for step_dir_gen: table of directed moves plus random moves, each traced
// cycle by cycle against a waveform computed from the pulse timing rules.
module tb_step_dir_gen;

    localparam int CNT_W = 32;
    localparam int TIM_W = 16;

    // Clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             resetn;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [CNT_W-1:0] cmd_steps;
    logic [TIM_W-1:0] step_period;
    logic [TIM_W-1:0] step_high;
    logic [TIM_W-1:0] dir_setup;
    logic             step_active_high;
    logic             invert_dir;
    logic             abort;
    logic             pos_set_valid;
    logic [CNT_W-1:0] pos_set_value;
    logic             step;
    logic             dir;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] position;
    logic [1:0]       state_dbg;

    step_dir_gen #(.CNT_W(CNT_W), .TIM_W(TIM_W)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_steps        (cmd_steps),
        .step_period      (step_period),
        .step_high        (step_high),
        .dir_setup        (dir_setup),
        .step_active_high (step_active_high),
        .invert_dir       (invert_dir),
        .abort            (abort),
        .pos_set_valid    (pos_set_valid),
        .pos_set_value    (pos_set_value),
        .step             (step),
        .dir              (dir),
        .busy             (busy),
        .done             (done),
        .position         (position),
        .state_dbg        (state_dbg)
    );

    int errors = 0;
    int checks = 0;

    logic [CNT_W-1:0] model_pos;
    logic             model_dir;

    // Loopback receiver: counts active edges with direction = dir ^ invert_dir
    int   rx_count = 0;
    logic step_prev = 1'b0;
    always @(negedge clk) begin
        if ((step !== step_prev) && (step === step_active_high)) begin
            rx_count <= rx_count + (((dir ^ invert_dir) == 1'b1) ? 1 : -1);
        end
        step_prev <= step;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one move and compare every cycle until one cycle past done.
    task automatic run_move(input int steps, input int period, input int high, input int setup,
                            input bit ah, input bit inv, input int abort_k,
                            input bit ps_with_cmd, input bit ps_busy, output int done_k);
        int n, h, l, s, m, k_end, sign, cnt, rx0;
        logic exp_dir, exp_step, exp_busy, exp_done, active;
        logic [CNT_W-1:0] pos0, exp_pos;
        n = (steps < 0) ? -steps : steps;
        h = (high == 0) ? 1 : high;
        l = (period > high) ? period - high : 1;
        s = setup;
        sign = (steps > 0) ? 1 : -1;
        if (n == 0) begin
            m = 0;
            k_end = 0;
            exp_dir = model_dir;
        end else begin
            exp_dir = (steps > 0) ^ inv;
            m = n;
            if (abort_k >= 0 && abort_k <= s) begin
                m = 0;
            end else if (abort_k > s) begin
                m = (abort_k - (s + 1)) / (h + l) + 1;
                if (m > n) m = n;
            end
            k_end = (m == 0) ? abort_k + 1 : s + 1 + m * (h + l);
        end
        pos0 = model_pos;
        rx0 = rx_count;

        cmd_valid = 1'b1;
        cmd_steps = CNT_W'(steps);
        step_period = TIM_W'(period);
        step_high = TIM_W'(high);
        dir_setup = TIM_W'(setup);
        step_active_high = ah;
        invert_dir = inv;
        pos_set_valid = ps_with_cmd;
        pos_set_value = $urandom;
        done_k = -1;
        tick();
        cmd_valid = 1'b0;

        for (int k = 0; k <= k_end + 1; k++) begin
            if (k > 0) tick();
            cnt = (k < s + 1) ? 0 : (k - (s + 1)) / (h + l) + 1;
            if (cnt > m) cnt = m;
            active = (k < k_end) && (k >= s + 1) && (((k - (s + 1)) % (h + l)) < h);
            exp_step = active ? ah : ~ah;
            exp_busy = (k < k_end);
            exp_done = (k == k_end);
            exp_pos = pos0 + CNT_W'(sign * cnt);
            check("trace{step,dir,busy,done,ready,pos}",
                  64'({step, dir, busy, done, cmd_ready, position}),
                  64'({exp_step, exp_dir, exp_busy, exp_done, ~exp_busy, exp_pos}));
            if (done === 1'b1 && done_k < 0) done_k = k;
            // Next-edge inputs; timing inputs are scrambled to show they are latched
            abort = (k == abort_k);
            pos_set_valid = ps_busy && (k == 0) && (n > 0);
            pos_set_value = $urandom;
            cmd_steps = $urandom;
            step_period = TIM_W'($urandom_range(0, 20));
            step_high = TIM_W'($urandom_range(0, 20));
            dir_setup = TIM_W'($urandom_range(0, 20));
        end
        abort = 1'b0;
        pos_set_valid = 1'b0;
        model_pos = pos0 + CNT_W'(sign * m);
        model_dir = exp_dir;
        check("rx_loopback_delta", 64'(rx_count - rx0), 64'((n == 0) ? 0 : sign * m));
    endtask

    task automatic do_pos_set(input logic [CNT_W-1:0] val);
        pos_set_valid = 1'b1;
        pos_set_value = val;
        tick();
        pos_set_valid = 1'b0;
        check("pos_set_load", 64'(position), 64'(val));
        model_pos = val;
    endtask

    typedef struct {
        bit               use_ps;
        logic [CNT_W-1:0] ps_val;
        int               steps;
        int               period;
        int               high;
        int               setup;
        bit               ah;
        bit               inv;
        int               abort_k;
        logic [CNT_W-1:0] exp_pos;
        int               exp_done_k;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int dk;
        vecs[0] = '{1'b1, 32'h0,        3, 10, 4, 2, 1'b1, 1'b0, -1, 32'h3,        33};
        vecs[1] = '{1'b1, 32'h0,       -2, 10, 4, 2, 1'b1, 1'b1, -1, 32'hFFFFFFFE, 23};
        vecs[2] = '{1'b1, 32'h0,        4,  3, 5, 0, 1'b0, 1'b0, -1, 32'h4,        25};
        vecs[3] = '{1'b1, 32'h0,        5, 10, 4, 1, 1'b1, 1'b0, 13, 32'h2,        22};
        vecs[4] = '{1'b0, 32'h0,        5, 10, 4, 4, 1'b1, 1'b0,  1, 32'h2,         2};
        vecs[5] = '{1'b0, 32'h0,        0, 10, 4, 2, 1'b1, 1'b0, -1, 32'h2,         0};
        vecs[6] = '{1'b1, 32'h7FFFFFFF, 1, 10, 4, 0, 1'b1, 1'b0, -1, 32'h80000000, 11};
        vecs[7] = '{1'b1, 32'hFFFFFFFF, 1, 10, 4, 0, 1'b1, 1'b0, -1, 32'h0,        11};
        vecs[8] = '{1'b0, 32'h0,       -1,  2, 0, 0, 1'b1, 1'b0, -1, 32'hFFFFFFFF,  4};

        resetn = 1'b0;
        cmd_valid = 1'b0;
        cmd_steps = '0;
        step_period = '0;
        step_high = '0;
        dir_setup = '0;
        step_active_high = 1'b1;
        invert_dir = 1'b0;
        abort = 1'b0;
        pos_set_valid = 1'b0;
        pos_set_value = '0;
        tick();
        tick();
        check("reset{step,dir,busy,done,ready,pos}",
              64'({step, dir, busy, done, cmd_ready, position}), 64'({1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0}));
        resetn = 1'b1;
        model_pos = '0;
        model_dir = 1'b0;
        tick();

        // Directed table
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].use_ps) do_pos_set(vecs[i].ps_val);
            run_move(vecs[i].steps, vecs[i].period, vecs[i].high, vecs[i].setup, vecs[i].ah,
                     vecs[i].inv, vecs[i].abort_k, 1'b0, 1'b0, dk);
            check($sformatf("vec%0d_position", i), 64'(position), 64'(vecs[i].exp_pos));
            check($sformatf("vec%0d_done_cycle", i), 64'(dk), 64'(vecs[i].exp_done_k));
        end

        // Abort in IDLE is ignored: next move runs to completion
        abort = 1'b1;
        tick();
        abort = 1'b0;
        run_move(2, 4, 2, 0, 1'b1, 1'b0, -1, 1'b0, 1'b0, dk);
        check("idle_abort_ignored_done", 64'(dk), 64'(9));

        // Accept and pos_set in the same cycle, then pos_set while busy
        run_move(1, 3, 1, 1, 1'b1, 1'b0, -1, 1'b1, 1'b1, dk);

        // Random moves
        for (int r = 0; r < 40; r++) begin
            int st, pe, hi, se, hh, ll, nat, ab;
            bit aa, iv;
            st = int'($urandom_range(0, 12)) - 6;
            pe = $urandom_range(0, 10);
            hi = $urandom_range(0, 6);
            se = $urandom_range(0, 4);
            aa = 1'($urandom_range(0, 1));
            iv = 1'($urandom_range(0, 1));
            hh = (hi == 0) ? 1 : hi;
            ll = (pe > hi) ? pe - hi : 1;
            nat = se + 1 + ((st < 0) ? -st : st) * (hh + ll);
            ab = ($urandom_range(0, 2) == 0 && st != 0) ? int'($urandom_range(0, nat)) : -1;
            if ($urandom_range(0, 4) == 0) do_pos_set($urandom);
            run_move(st, pe, hi, se, aa, iv, ab, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), dk);
        end

        // Reset in the middle of a high phase
        do_pos_set(32'h5);
        cmd_valid = 1'b1;
        cmd_steps = 32'd3;
        step_period = 16'd10;
        step_high = 16'd4;
        dir_setup = 16'd0;
        step_active_high = 1'b1;
        invert_dir = 1'b0;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        check("pre_reset_step_high", 64'({step, position}), 64'({1'b1, 32'h6}));
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        check("midmove_reset{step,dir,busy,done,ready,pos}",
              64'({step, dir, busy, done, cmd_ready, position}), 64'({1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0}));
        tick();
        check("post_reset_idle", 64'({step, busy, position}), 64'({1'b0, 1'b0, 32'h0}));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/step_dir_gen.md
Name: step_dir_gen

Overview:
- Step/dir pulse generator: the transmit side of the step/dir interface that the position counter decodes.
- Accepts signed relative move commands via a valid/ready handshake and emits timed step pulses with guaranteed dir setup time.
- Keeps an internal 32-bit position using the same count convention as the receiver: direction = dir ^ invert_dir; 1 = +1.
- Sits between the motion command register block and the physical step/dir pins, or drives an on-chip receiver in loopback.

Parameters:
CNT_W, 32, width of cmd_steps and position
TIM_W, 16, width of timing inputs

Ports:
clk  in  1  clock
resetn  in  1  synchronous, active-low reset
cmd_valid  in  1  move command valid
cmd_ready  out  1  high only in IDLE
cmd_steps  in  CNT_W  signed relative step count
step_period  in  TIM_W  clocks per step (high + low)
step_high  in  TIM_W  active pulse width, clocks
dir_setup  in  TIM_W  extra clocks between dir change and first active edge
step_active_high  in  1  1: active level high; 0: active level low
invert_dir  in  1  inverts dir polarity
abort  in  1  stop after the current pulse
pos_set_valid  in  1  load position (IDLE only)
pos_set_value  in  CNT_W  value to load
step  out  1  step output, registered
dir  out  1  dir output, registered
busy  out  1  high whenever state != IDLE
done  out  1  1-cycle pulse at command completion
position  out  CNT_W  commanded position, registered

Behaviour:
- Reset (resetn=0 sampled at posedge clk): state IDLE; step=!step_active_high; dir=0; position=0; busy=0; done=0; abort flag cleared; cmd_ready=1 from the following cycle. Reset mid-move discards the move without completing the current pulse.
- States: IDLE, SETUP, PULSE_HI, PULSE_LO.
- In IDLE, step tracks !step_active_high every cycle.
- IDLE, accept (cmd_valid & cmd_ready) at edge N:
  - cmd_steps==0: done=1 for cycle N+1; remain in IDLE; step/dir unchanged.
  - Otherwise latch: remaining = |cmd_steps| (unsigned; -2^31 gives 2^31); step_high, step_period, dir_setup, step_active_high.
  - dir <= (cmd_steps>0) ^ invert_dir at edge N; timer = dir_setup; state -> SETUP.
- pos_set_valid in IDLE, no accept that cycle: position <= pos_set_value. Ignored when not IDLE. If accept and pos_set coincide, the accept wins.
- SETUP: if timer==0, go to PULSE_HI and drive step active at the next edge; else timer--.
  - Result: dir is stable dir_setup+1 clocks before the active edge. With dir_setup=0, the first active edge is at N+1.
- PULSE_HI, on entry:
  - step active; position +1 for positive moves, -1 for negative (wraps mod 2^CNT_W); remaining--.
  - Held H = max(step_high,1) cycles, then step inactive and state -> PULSE_LO.
- PULSE_LO: held L cycles, L = step_period - step_high if step_period > step_high, else 1.
  - At the end: if remaining==0 or abort flag set, go IDLE with done=1 for one cycle and busy=0; else PULSE_HI.
  - Step period = H+L clocks; no runt pulses.
- abort (sampled in any non-IDLE state) sets a sticky flag:
  - In SETUP: IDLE immediately with done pulse; no step emitted.
  - In PULSE_HI/PULSE_LO: the current pulse completes full H+L, then IDLE.
  - abort in IDLE is ignored.
- Timing inputs and polarity changes while busy have no effect until the next accept. invert_dir is sampled only at accept.
- Position reflects the number of active edges emitted, updated on the same edge step goes active.

Test Plan:
- cmd_steps=3, period=10, high=4, setup=2, active_high=1, invert=0 -> dir=1 after accept edge N; first rising step at N+3; 3 pulses 4 high / 6 low; position 0->3; done 1 cycle after last low phase; busy then 0.
- cmd_steps=-2, invert_dir=1 -> dir=1; 2 pulses; position=0xFFFFFFFE. A loopback receiver with identical invert_dir/active_high counts to 0xFFFFFFFE.
- step_active_high=0, cmd_steps=4, period=3, high=5 -> step idles high; low pulses 5 clocks, high gaps 1 clock; position=4.
- cmd_steps=5, abort asserted in PULSE_HI of pulse 2 -> pulse 2 completes full width; position=2; done; IDLE. abort in SETUP -> no pulses, position unchanged, done.
- cmd_steps=0 -> done at N+1, no step toggle. pos_set 0x7FFFFFFF then +1 step -> 0x80000000. pos_set 0xFFFFFFFF then +1 -> 0. pos_set while busy is ignored.
- resetn low during PULSE_HI -> next cycle step inactive, position=0, busy=0, cmd_ready=1.
